cordicl: RTL and testbench

Shift-add logarithm engine: the inverse of the team's `cordicn` exponential block. It takes a Q32.32 value `y` in (0, 1.0] and returns `x ≈ -ln(y)` in Q16.16. It uses the same 32-entry, 2048-bit lookup-table bus as `cordicn`, so both blocks can share one table ROM. A round trip `cordicn(cordicl(y))` reproduces `y` within table precision.

---
 rtl/cordicl_pkg.sv | 26 ++
 rtl/cordicl_if.sv | 23 ++
 rtl/cordicl_step.sv | 37 +++
 rtl/cordicl.sv | 90 +++++++++
 tb/tb_cordicl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/cordicl_pkg.sv
// Shared definitions for the cordicl/cordicn shift-add log/exp pair:
// fixed widths, the Q32.32 unit constant, FSM encodings and table slicing.
package cordicl_pkg;

  localparam int DATA_W = 64;
  localparam int RES_W  = 32;
  localparam int TAB_N  = 32;
  localparam int CNT_W  = $clog2(TAB_N);

  localparam logic [DATA_W-1:0] ONE = 64'h0000_0001_0000_0000;

  typedef enum logic [0:0] {
    E_IDLE = 1'b0,
    E_CALC = 1'b1
  } state_e;

  // tab[k] lives at bits (31-k)*64 +: 64, so entry 0 is the top slice.
  // For a 5-bit k, 31-k is simply ~k.
  function automatic logic [DATA_W-1:0] tab_slice(input logic [TAB_N*DATA_W-1:0] lookup,
                                                  input logic [CNT_W-1:0]        k);
    logic [10:0] idx;
    idx       = {~k, 6'd0};
    tab_slice = lookup[idx +: DATA_W];
  endfunction

endpackage

// File: rtl/cordicl_if.sv
// Request/result bundle for cordicl: operand and table in, result out.
interface cordicl_if;
  import cordicl_pkg::*;

  logic                    en;
  logic [DATA_W-1:0]       y;
  logic [TAB_N*DATA_W-1:0] lookup;
  logic [RES_W-1:0]        x;
  logic                    valid;
  logic                    busy;
  logic                    err;

  modport master (
    output en, y, lookup,
    input  x, valid, busy, err
  );

  modport slave (
    input  en, y, lookup,
    output x, valid, busy, err
  );

endinterface

// File: rtl/cordicl_step.sv
// One shift-add log iteration: try to shrink p towards v by the factor
// selected by k, and accumulate the matching table entry when it fits.
module cordicl_step
  import cordicl_pkg::*;
(
  input  logic [DATA_W-1:0] p,
  input  logic [DATA_W-1:0] v,
  input  logic [CNT_W-1:0]  k,
  input  logic [DATA_W-1:0] tab_k,
  input  logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] p_nxt,
  output logic [DATA_W-1:0] acc_nxt
);

  logic [DATA_W-1:0] cand;
  logic [5:0]        sh;

  // Coarse steps divide by a power of two; fine steps multiply by (1 - 2^-(k-14)).
  always_comb begin
    cand    = p;
    sh      = 6'd0;
    p_nxt   = p;
    acc_nxt = acc;
    if (k < 5'd16) begin
      sh   = 6'd16 - {1'b0, k};
      cand = p >> sh;
    end else begin
      sh   = {1'b0, k} - 6'd14;
      cand = p - (p >> sh);
    end
    if (cand >= v) begin
      p_nxt   = cand;
      acc_nxt = acc + tab_k;
    end
  end

endmodule

// File: rtl/cordicl.sv
// Iterative -ln(y) engine: Q32.32 operand in (0,1], Q16.16 result after
// 32 shift-add iterations, one per clock. Out-of-domain operands are
// answered immediately with err set.
module cordicl
  import cordicl_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  cordicl_if.slave bus
);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] p;
  logic [DATA_W-1:0] v;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] tab_k;
  logic [DATA_W-1:0] p_nxt;
  logic [DATA_W-1:0] acc_nxt;

  // Saturate the Q32.32 accumulator into the Q16.16 result, truncating the low bits.
  function automatic logic [RES_W-1:0] sat_x(input logic [DATA_W-1:0] a);
    if (a[63:48] != 16'd0) sat_x = 32'hFFFF_FFFF;
    else                   sat_x = a[47:16];
  endfunction

  assign tab_k = tab_slice(bus.lookup, cnt);

  cordicl_step u_step (
    .p       (p),
    .v       (v),
    .k       (cnt),
    .tab_k   (tab_k),
    .acc     (acc),
    .p_nxt   (p_nxt),
    .acc_nxt (acc_nxt)
  );

  // Control FSM: accept/reject requests, run the iterations, publish the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= E_IDLE;
      cnt       <= '0;
      p         <= ONE;
      acc       <= '0;
      bus.x     <= '0;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        E_IDLE: begin
          if (bus.en) begin
            if (bus.y == '0) begin
              bus.x     <= 32'hFFFF_FFFF;
              bus.err   <= 1'b1;
              bus.valid <= 1'b1;
            end else if (bus.y > ONE) begin
              bus.x     <= '0;
              bus.err   <= 1'b1;
              bus.valid <= 1'b1;
            end else begin
              v        <= bus.y;
              p        <= ONE;
              acc      <= '0;
              cnt      <= '0;
              bus.busy <= 1'b1;
              state    <= E_CALC;
            end
          end
        end
        E_CALC: begin
          p   <= p_nxt;
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(TAB_N - 1)) begin
            bus.x     <= sat_x(acc_nxt);
            bus.err   <= 1'b0;
            bus.valid <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= E_IDLE;
          end
        end
        default: state <= E_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordicl.sv
// Bench for cordicl: directed domain/edge cases, en-during-CALC, reset
// abort and priority, then a back-to-back chain of random operands whose
// results are compared to -ln(y) and pushed through an exp round trip.
module tb_cordicl;
  import cordicl_pkg::*;

  localparam real Q32 = 4294967296.0;
  localparam real Q16 = 65536.0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cordicl_if bus ();

  cordicl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input real obs, input real exp, input real tol);
    logic ok;
    checks++;
    ok = ((obs - exp) <= tol) && ((exp - obs) <= tol);
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%f expected=%f tol=%f", tag, obs, exp, tol);
    end
  endtask

  // Issue one request in the current cycle and wait (bounded) for its result.
  // lat counts cycles after the accepting edge; bcnt counts busy cycles before valid.
  task automatic issue(input logic [63:0] yv, output logic [31:0] xo, output logic eo,
                       output int lat, output int bcnt);
    bus.en = 1'b1;
    bus.y  = yv;
    @(posedge clk); #1;
    bus.en = 1'b0;
    bus.y  = {$urandom, $urandom};
    lat  = 1;
    bcnt = 0;
    while (!bus.valid && lat < 40) begin
      if (bus.busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    xo = bus.x;
    eo = bus.err;
  endtask

  initial begin
    logic [31:0] xo;
    logic        eo;
    int          lat, bcnt, nval, vcyc;
    logic [63:0] yv;
    real         m, yr, ideal, yrec;
    int          e;

    // Coarse entries carry (16-k)*ln2 to match a divide by 2^(16-k);
    // fine entries carry -ln(1 - 2^-(k-14)).
    for (int k = 0; k < TAB_N; k++) begin
      real         r;
      logic [63:0] t;
      if (k < 16) r = real'(16 - k) * $ln(2.0);
      else        r = -$ln(1.0 - 2.0 ** (-(k - 14)));
      t = longint'($floor(r * Q32));
      bus.lookup[(31 - k) * 64 +: 64] = t;
    end

    rst    = 1'b1;
    bus.en = 1'b0;
    bus.y  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 64'(bus.x), 64'h0);
    chk("rst_valid", 64'(bus.valid), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_err", 64'(bus.err), 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // y = 0: immediate error with saturated result
    issue(64'h0, xo, eo, lat, bcnt);
    chk("zero_lat", 64'(lat), 64'd1);
    chk("zero_err", 64'(eo), 64'd1);
    chk("zero_x", 64'(xo), 64'hFFFF_FFFF);
    chk("zero_busy", 64'(bcnt), 64'd0);

    // y just above 1.0: immediate error with zero result
    issue(64'h0000_0001_0000_0001, xo, eo, lat, bcnt);
    chk("big_lat", 64'(lat), 64'd1);
    chk("big_err", 64'(eo), 64'd1);
    chk("big_x", 64'(xo), 64'h0);

    // y = 1.0: full iteration run, result zero
    issue(ONE, xo, eo, lat, bcnt);
    chk("one_lat", 64'(lat), 64'd33);
    chk("one_busy_cycles", 64'(bcnt), 64'd32);
    chk("one_x", 64'(xo), 64'h0);
    chk("one_err", 64'(eo), 64'd0);
    chk("one_busy_at_valid", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    chk("one_single_pulse", 64'(bus.valid), 64'd0);

    // y = 0.5 -> ln2
    issue(64'h0000_0000_8000_0000, xo, eo, lat, bcnt);
    chk("half_lat", 64'(lat), 64'd33);
    chk_near("half_x", real'(xo), real'(32'h0000_B172), 1.0);
    chk("half_err", 64'(eo), 64'd0);

    // y = 2^-16 -> 16*ln2
    issue(64'h0000_0000_0001_0000, xo, eo, lat, bcnt);
    chk_near("tiny_x", real'(xo), real'(32'h000B_1721), 1.0);

    // en pulse during CALC must be ignored (y=0 would otherwise raise err)
    bus.en = 1'b1;
    bus.y  = 64'h0000_0000_C000_0000;
    @(posedge clk); #1;
    bus.en = 1'b0;
    nval = 0;
    vcyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.valid) begin
        nval++;
        vcyc = c;
        xo   = bus.x;
        eo   = bus.err;
      end
      bus.en = (c == 5);
      bus.y  = '0;
      @(posedge clk); #1;
    end
    chk("ign_count", 64'(nval), 64'd1);
    chk("ign_cycle", 64'(vcyc), 64'd33);
    chk("ign_err", 64'(eo), 64'd0);
    chk_near("ign_x", real'(xo), -$ln(0.75) * Q16, 4.0);

    // reset in the middle of an operation aborts it
    bus.en = 1'b1;
    bus.y  = 64'h0000_0000_C000_0000;
    @(posedge clk); #1;
    bus.en = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_x", 64'(bus.x), 64'h0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    nval = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.valid) nval++;
      @(posedge clk); #1;
    end
    chk("abort_no_valid", 64'(nval), 64'd0);

    // reset wins over a simultaneous request
    bus.en = 1'b1;
    bus.y  = 64'h0;
    rst    = 1'b1;
    @(posedge clk); #1;
    rst    = 1'b0;
    bus.en = 1'b0;
    chk("prio_valid", 64'(bus.valid), 64'd0);
    chk("prio_err", 64'(bus.err), 64'd0);

    // back-to-back random operands, next request issued in each valid cycle
    for (int i = 0; i < 10; i++) begin
      m  = 0.6 + 0.4 * real'($urandom_range(0, 1000000)) / 1000000.0;
      e  = $urandom_range(0, 7);
      yv = 64'(longint'($floor(m * Q32))) >> e;
      yr = real'(yv) / Q32;
      issue(yv, xo, eo, lat, bcnt);
      chk("rand_lat", 64'(lat), 64'd33);
      chk("rand_err", 64'(eo), 64'd0);
      ideal = -$ln(yr) * Q16;
      chk_near("rand_x", real'(xo), ideal, 4.0);
      yrec = $exp(-real'(xo) / Q16);
      chk_near("rand_roundtrip", (yrec - yr) / yr, 0.0, 1.0 / 16384.0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
